// File: rtl/hilo_mdu_pkg.sv
// ---------------------------------------------------------------------------
// hilo_mdu_pkg
// Shared definitions for the HI/LO multiply/divide unit and for any block that
// decodes ALU control codes: operand width, MDU op codes, and the FSM state
// encoding.
// ---------------------------------------------------------------------------
package hilo_mdu_pkg;

    localparam int XLEN = 32;

    // MDU operation codes carried on the 6-bit ALU control bus
    localparam logic [5:0] OP_MFHI  = 6'd16;
    localparam logic [5:0] OP_MTHI  = 6'd17;
    localparam logic [5:0] OP_MFLO  = 6'd18;
    localparam logic [5:0] OP_MTLO  = 6'd19;
    localparam logic [5:0] OP_MULT  = 6'd24;
    localparam logic [5:0] OP_MULTU = 6'd25;
    localparam logic [5:0] OP_DIV   = 6'd26;
    localparam logic [5:0] OP_DIVU  = 6'd27;
    localparam logic [5:0] OP_MUL   = 6'd51;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL     = 2'd1,
        ST_DIV     = 2'd2,
        ST_DIV_FIX = 2'd3
    } mdu_state_t;

    function automatic logic is_mdu_op(input logic [5:0] code);
        case (code)
            OP_MFHI, OP_MTHI, OP_MFLO, OP_MTLO,
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MUL: is_mdu_op = 1'b1;
            default:                                     is_mdu_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/hilo_mdu_div_radix2.sv
// ---------------------------------------------------------------------------
// div_radix2
// Iterative radix-2 restoring divider. Operands are converted to magnitudes
// at start, one quotient bit is produced per cycle for XLEN cycles, and the
// following cycle (valid=1) presents the sign-corrected results.
//   clk, rst_n          clock, asynchronous active-low reset
//   start               load new operands and begin iterating
//   dividend, divisor   operands (sampled only on start)
//   is_signed           treat operands as two's complement
//   quotient, remainder final results, meaningful while valid=1
//   valid               one-cycle pulse after the last quotient bit
// ---------------------------------------------------------------------------
module div_radix2 #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            is_signed,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            valid
);
    localparam int CW = $clog2(XLEN);

    logic [CW-1:0]   cnt;
    logic            running;
    logic            fix;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] dvsr;
    logic [XLEN-1:0] dvd_orig;
    logic            neg_q;
    logic            neg_r;
    logic            div0;

    logic [XLEN-1:0] dvd_abs;
    logic [XLEN-1:0] dvsr_abs;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   rem_sub;
    logic            ge;

    always_comb begin
        dvd_abs  = (is_signed && dividend[XLEN-1]) ? -dividend : dividend;
        dvsr_abs = (is_signed && divisor[XLEN-1])  ? -divisor  : divisor;
        // Shift the next dividend bit (MSB of the quotient register) into the
        // partial remainder, then try to subtract the divisor.
        rem_sh   = {rem, quo[XLEN-1]};
        rem_sub  = rem_sh - {1'b0, dvsr};
        ge       = (rem_sh >= {1'b0, dvsr});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            running  <= 1'b0;
            fix      <= 1'b0;
            quo      <= '0;
            rem      <= '0;
            dvsr     <= '0;
            dvd_orig <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div0     <= 1'b0;
        end else if (start) begin
            cnt      <= '0;
            running  <= 1'b1;
            fix      <= 1'b0;
            quo      <= dvd_abs;
            rem      <= '0;
            dvsr     <= dvsr_abs;
            dvd_orig <= dividend;
            neg_q    <= is_signed & (dividend[XLEN-1] ^ divisor[XLEN-1]);
            neg_r    <= is_signed & dividend[XLEN-1];
            div0     <= (divisor == '0);
        end else if (running) begin
            rem <= ge ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0];
            quo <= {quo[XLEN-2:0], ge};
            cnt <= cnt + CW'(1);
            if (cnt == CW'(XLEN - 1)) begin
                running <= 1'b0;
                fix     <= 1'b1;
            end
        end else begin
            fix <= 1'b0;
        end
    end

    // Divide by zero bypasses sign correction: all-ones quotient and the
    // untouched dividend as remainder. The most-negative / -1 case falls out
    // naturally: magnitude quotient 0x80..0 negates to itself.
    always_comb begin
        quotient  = div0 ? '1       : (neg_q ? -quo : quo);
        remainder = div0 ? dvd_orig : (neg_r ? -rem : rem);
        valid     = fix;
    end

endmodule

// File: rtl/hilo_mdu.sv
// ---------------------------------------------------------------------------
// hilo_mdu
// Multiply/divide unit owning the architectural HI/LO registers.
//   clk, rst_n     clock, asynchronous active-low reset
//   start          EX-stage request valid for the code on AluControl
//   AluControl     6-bit ALU control code (MDU codes in hilo_mdu_pkg)
//   src_a, src_b   rs / rt operands
//   stall          request present but unit busy; not accepted this cycle
//   done           one-cycle pulse when mult/multu/mul/div/divu completes
//   result         mfhi/mflo data (same cycle) or mul product low half
//   hi, lo         architectural HI/LO registers
// Handshake: an MDU request is accepted on the rising edge where start=1 and
// the FSM is IDLE; while busy, start on an MDU code raises stall and the
// requester must hold the request until stall drops.
// ---------------------------------------------------------------------------
module hilo_mdu #(
    parameter int XLEN    = hilo_mdu_pkg::XLEN,
    parameter int MUL_LAT = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [5:0]      AluControl,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    import hilo_mdu_pkg::*;

    localparam int CNT_W = $clog2(XLEN + MUL_LAT);

    mdu_state_t      state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [5:0]      op_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;

    logic            mdu_op;
    logic            accept;
    logic            mul_last;
    logic            mul_signed;
    logic [2*XLEN-1:0] ext_a, ext_b, prod;

    logic [XLEN-1:0] div_q, div_r;
    logic            div_valid;
    logic            div_start;

    assign mdu_op    = is_mdu_op(AluControl);
    assign accept    = start && mdu_op && (state == ST_IDLE);
    assign div_start = accept && ((AluControl == OP_DIV) || (AluControl == OP_DIVU));
    assign mul_last  = (state == ST_MUL) && (cnt == CNT_W'(MUL_LAT - 1));

    // Inline multiplier on the latched operands. Sign- or zero-extending to
    // 2*XLEN makes the low 2*XLEN bits of the product correct for both cases.
    always_comb begin
        mul_signed = (op_q != OP_MULTU);
        ext_a = mul_signed ? {{XLEN{a_q[XLEN-1]}}, a_q} : {{XLEN{1'b0}}, a_q};
        ext_b = mul_signed ? {{XLEN{b_q[XLEN-1]}}, b_q} : {{XLEN{1'b0}}, b_q};
        prod  = ext_a * ext_b;
    end

    div_radix2 #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .dividend  (src_a),
        .divisor   (src_b),
        .is_signed (AluControl == OP_DIV),
        .quotient  (div_q),
        .remainder (div_r),
        .valid     (div_valid)
    );

    always_comb begin
        state_next = state;
        done       = 1'b0;
        result     = '0;
        stall      = start && mdu_op && (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (start && (AluControl == OP_MFHI)) result = hi;
                if (start && (AluControl == OP_MFLO)) result = lo;
                if (accept) begin
                    case (AluControl)
                        OP_MULT, OP_MULTU, OP_MUL: state_next = ST_MUL;
                        OP_DIV, OP_DIVU:           state_next = ST_DIV;
                        default:                   state_next = ST_IDLE;
                    endcase
                end
            end
            ST_MUL: begin
                if (mul_last) begin
                    done       = 1'b1;
                    state_next = ST_IDLE;
                    if (op_q == OP_MUL) result = prod[XLEN-1:0];
                end
            end
            ST_DIV: begin
                if (cnt == CNT_W'(XLEN - 1)) state_next = ST_DIV_FIX;
            end
            ST_DIV_FIX: begin
                done       = div_valid;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                cnt  <= '0;
                op_q <= AluControl;
                a_q  <= src_a;
                b_q  <= src_b;
                if (AluControl == OP_MTHI) hi <= src_a;
                if (AluControl == OP_MTLO) lo <= src_a;
            end else if (state != ST_IDLE) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (mul_last && (op_q != OP_MUL)) begin
                hi <= prod[2*XLEN-1:XLEN];
                lo <= prod[XLEN-1:0];
            end
            if ((state == ST_DIV_FIX) && div_valid) begin
                lo <= div_q;
                hi <= div_r;
            end
        end
    end

endmodule

// File: tb/tb_hilo_mdu.sv
// ---------------------------------------------------------------------------
// tb_hilo_mdu
// Directed bench for hilo_mdu: a vector table of complete mult/div/mul
// transactions plus hand-written sequences for moves, stalls, back-to-back
// requests and reset mid-division.
// ---------------------------------------------------------------------------
module tb_hilo_mdu;
    import hilo_mdu_pkg::*;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [5:0]      AluControl;
    logic [XLEN-1:0] src_a, src_b;
    logic            stall, done;
    logic [XLEN-1:0] result, hi, lo;

    hilo_mdu #(.XLEN(XLEN), .MUL_LAT(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .AluControl (AluControl),
        .src_a      (src_a),
        .src_b      (src_b),
        .stall      (stall),
        .done       (done),
        .result     (result),
        .hi         (hi),
        .lo         (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        int              lat;
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
        logic [XLEN-1:0] res;
    } vec_t;

    int              n_checks = 0;
    int              n_fail   = 0;
    logic [XLEN-1:0] model_hi = '0;
    logic [XLEN-1:0] model_lo = '0;
    vec_t            vecs[13];

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one multi-cycle op from IDLE and check latency, result at done,
    // HI/LO hold while busy and HI/LO after completion.
    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        lat = 0;
        @(negedge clk);
        AluControl = v.op; src_a = v.a; src_b = v.b; start = 1'b1;
        #1 chk($sformatf("v%0d_stall_idle", idx), {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0; AluControl = 6'd0;
        src_a = $urandom_range(0, 32'hFFFF); src_b = 32'd0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
        end
        chk($sformatf("v%0d_latency", idx), lat, v.lat);
        chk($sformatf("v%0d_result", idx), result, v.res);
        chk($sformatf("v%0d_hi_hold", idx), hi, model_hi);
        chk($sformatf("v%0d_lo_hold", idx), lo, model_lo);
        @(negedge clk);
        chk($sformatf("v%0d_done_clear", idx), {31'd0, done}, 32'd0);
        chk($sformatf("v%0d_hi", idx), hi, v.hi);
        chk($sformatf("v%0d_lo", idx), lo, v.lo);
        model_hi = v.hi;
        model_lo = v.lo;
    endtask

    initial begin
        logic saw_done;
        rst_n = 1'b0; start = 1'b0; AluControl = 6'd0; src_a = '0; src_b = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_result", result, 32'd0);
        rst_n = 1'b1;

        // mthi / mfhi / mtlo / mflo
        @(negedge clk);
        start = 1'b1; AluControl = OP_MTHI; src_a = 32'h0000_1234;
        @(negedge clk);
        chk("mthi_hi", hi, 32'h0000_1234);
        chk("mthi_lo_untouched", lo, 32'd0);
        AluControl = OP_MFHI; src_a = 32'd0;
        #1 chk("mfhi_result", result, 32'h0000_1234);
        @(negedge clk);
        AluControl = OP_MTLO; src_a = 32'h0000_ABCD;
        @(negedge clk);
        chk("mtlo_lo", lo, 32'h0000_ABCD);
        AluControl = OP_MFLO;
        #1 chk("mflo_result", result, 32'h0000_ABCD);
        @(negedge clk);
        start = 1'b0;
        #1 chk("idle_result_zero", result, 32'd0);
        model_hi = 32'h0000_1234;
        model_lo = 32'h0000_ABCD;

        // Transaction table: {op, a, b, done latency, hi, lo, result at done}
        vecs[0]  = '{OP_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 2,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0};
        vecs[1]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 2,  32'h0000_0001, 32'hFFFF_FFFE, 32'h0};
        vecs[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h0};
        vecs[3]  = '{OP_DIVU,  32'd100,       32'd7,         33, 32'd2,         32'd14,        32'h0};
        vecs[4]  = '{OP_MUL,   32'd3,         32'hFFFF_FFFC, 2,  32'd2,         32'd14,        32'hFFFF_FFF4};
        vecs[5]  = '{OP_DIVU,  32'd5,         32'd0,         33, 32'd5,         32'hFFFF_FFFF, 32'h0};
        vecs[6]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0,         32'h8000_0000, 32'h0};
        vecs[7]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 33, 32'd1,         32'hFFFF_FFFD, 32'h0};
        vecs[8]  = '{OP_MULT,  32'h0001_0000, 32'h0001_0000, 2,  32'd1,         32'd0,         32'h0};
        vecs[9]  = '{OP_DIV,   32'hFFFF_FFFB, 32'd0,         33, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'h0};
        vecs[10] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2,  32'hFFFF_FFFE, 32'h0000_0001, 32'h0};
        vecs[11] = '{OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 2,  32'h0,         32'h0000_0001, 32'h0};
        vecs[12] = '{OP_DIVU,  32'hFFFF_FFF9, 32'd2,         33, 32'd1,         32'h7FFF_FFFC, 32'h0};
        for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

        // mflo held from cycle 5 of a divu: stalls through done, then reads quotient
        @(negedge clk);
        start = 1'b1; AluControl = OP_DIVU; src_a = 32'd100; src_b = 32'd7;
        @(posedge clk);
        #1 start = 1'b0; AluControl = 6'd0;
        for (int c = 1; c <= 34; c++) begin
            @(negedge clk);
            if (c == 3) begin
                start = 1'b1; AluControl = 6'd32;
                #1 chk("non_mdu_no_stall", {31'd0, stall}, 32'd0);
            end
            if (c == 5) begin
                AluControl = OP_MFLO;
                #1 chk("mflo_busy_stall", {31'd0, stall}, 32'd1);
            end
            if (c == 20) chk("mflo_mid_stall", {31'd0, stall}, 32'd1);
            if (c == 33) begin
                chk("div_done_pulse", {31'd0, done}, 32'd1);
                chk("done_cycle_stall", {31'd0, stall}, 32'd1);
            end
            if (c == 34) begin
                chk("mflo_after_stall", {31'd0, stall}, 32'd0);
                chk("mflo_after_result", result, 32'd14);
                chk("mflo_after_done", {31'd0, done}, 32'd0);
            end
        end
        start = 1'b0;
        model_hi = 32'd2; model_lo = 32'd14;

        // Back-to-back: multu held while mult runs, accepted the cycle after done
        @(negedge clk);
        start = 1'b1; AluControl = OP_MULT; src_a = 32'd2; src_b = 32'd3;
        @(posedge clk);
        #1 AluControl = OP_MULTU; src_a = 32'd4; src_b = 32'd5;
        @(negedge clk);
        chk("b2b_stall_c1", {31'd0, stall}, 32'd1);
        @(negedge clk);
        chk("b2b_done_c2", {31'd0, done}, 32'd1);
        @(negedge clk);
        chk("b2b_stall_c3", {31'd0, stall}, 32'd0);
        chk("b2b_lo_first", lo, 32'd6);
        @(posedge clk);
        #1 start = 1'b0; AluControl = 6'd0;
        @(negedge clk);
        chk("b2b_done_c4", {31'd0, done}, 32'd0);
        @(negedge clk);
        chk("b2b_done_c5", {31'd0, done}, 32'd1);
        @(negedge clk);
        chk("b2b_lo_second", lo, 32'd20);

        // Reset asserted at cycle 10 of a div abandons it
        @(negedge clk);
        start = 1'b1; AluControl = OP_DIV; src_a = 32'hFFFF_FFF9; src_b = 32'd2;
        @(posedge clk);
        #1 start = 1'b0; AluControl = 6'd0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("midrst_no_done", {31'd0, saw_done}, 32'd0);
        chk("midrst_hi_after", hi, 32'd0);
        model_hi = 32'd0; model_lo = 32'd0;
        run_vec('{OP_MULT, 32'd3, 32'd5, 2, 32'd0, 32'd15, 32'h0}, 99);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
